// File: rtl/jt12_i2s_tx.sv
// I2S transmitter for the JT12 FM accumulator outputs: 2-entry sample FIFO, gain + saturation,
// 32-bit frames. Define JT12_I2S_LJ_EN for left-justified alignment instead of I2S.
module jt12_i2s_tx #(
  parameter int unsigned CLKDIV = 4,
  parameter int unsigned GAIN   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_stb,
  input  logic [13:0] left,
  input  logic [13:0] right,
  output logic        bclk,
  output logic        lrck,
  output logic        sdata,
  output logic        overrun,
  output logic        underrun
);

  localparam logic [7:0] LP_DIV_LAST = 8'(CLKDIV - 1);
  localparam logic signed [16:0] LP_SAT_MAX = 17'sd32767;
  localparam logic signed [16:0] LP_SAT_MIN = -17'sd32768;

  logic [7:0]  r_div;
  logic        r_bclk;
  logic        r_lrck;
  logic        r_sdata;
  logic        r_ovr;
  logic        r_und;
  logic [4:0]  r_bitcnt;
  logic [31:0] r_frame;
  logic [27:0] r_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_cnt;

  logic        w_wrap;
  logic        w_shift;
  logic [4:0]  w_bitcnt_nxt;
  logic        w_pop_evt;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic [27:0] w_head;
  logic [31:0] w_frame_nxt;
  logic [4:0]  w_idx;
  logic        w_sdata_nxt;

  function automatic logic [15:0] f_scale(input logic [13:0] s);
    logic signed [16:0] v;
    v = $signed({{3{s[13]}}, s}) <<< GAIN;
    if (v > LP_SAT_MAX) begin
      return 16'h7FFF;
    end else if (v < LP_SAT_MIN) begin
      return 16'h8000;
    end else begin
      return v[15:0];
    end
  endfunction

  assign w_wrap       = (r_div == LP_DIV_LAST);
  assign w_shift      = w_wrap & r_bclk;
  assign w_bitcnt_nxt = r_bitcnt + 5'd1;
  assign w_pop_evt    = w_shift & (r_bitcnt == 5'd31);
  assign w_empty      = (r_cnt == 2'd0);
  assign w_full       = (r_cnt == 2'd2);
  assign w_pop        = w_pop_evt & ~w_empty;
  // A pop in the same cycle frees the slot the write lands in.
  assign w_push       = sample_stb & (~w_full | w_pop);
  assign w_head       = r_mem[r_rd_ptr];
  assign w_frame_nxt  = w_pop ? {f_scale(w_head[27:14]), f_scale(w_head[13:0])} : r_frame;

`ifdef JT12_I2S_LJ_EN
  // Bit 31-k; at k=0 this picks the MSB of the frame being popped.
  assign w_idx       = ~w_bitcnt_nxt;
  assign w_sdata_nxt = w_frame_nxt[w_idx];
`else
  // Bit 32-k; k=0 wraps to bit 0, the previous frame's right LSB, read before the pop lands.
  assign w_idx       = 5'd0 - w_bitcnt_nxt;
  assign w_sdata_nxt = r_frame[w_idx];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div    <= 8'd0;
      r_bclk   <= 1'b0;
      r_lrck   <= 1'b0;
      r_sdata  <= 1'b0;
      r_ovr    <= 1'b0;
      r_und    <= 1'b0;
      r_bitcnt <= 5'd0;
      r_frame  <= 32'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      r_div <= w_wrap ? 8'd0 : r_div + 8'd1;
      if (w_wrap) begin
        r_bclk <= ~r_bclk;
      end
      if (w_shift) begin
        r_bitcnt <= w_bitcnt_nxt;
        r_lrck   <= w_bitcnt_nxt[4];
        r_sdata  <= w_sdata_nxt;
      end
      r_frame <= w_frame_nxt;
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      r_ovr <= sample_stb & ~w_push;
      r_und <= w_pop_evt & w_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {left, right};
    end
  end

  assign bclk     = r_bclk;
  assign lrck     = r_lrck;
  assign sdata    = r_sdata;
  assign overrun  = r_ovr;
  assign underrun = r_und;

endmodule

// File: tb/tb_jt12_i2s_tx.sv
// Bench for jt12_i2s_tx: two instances (GAIN 2 and 3) share stimulus; frames are deserialized
// from the serial lines and checked against a scoreboard filled when samples are strobed.
module tb_jt12_i2s_tx;

  localparam int C      = 2;
  localparam int P      = 64 * C;
  localparam int RST_PH = 20 * 2 * C + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic [13:0] left = '0;
  logic [13:0] right = '0;
  logic        bclk_a, lrck_a, sdata_a, ovr_a, und_a;
  logic        bclk_b, lrck_b, sdata_b, ovr_b, und_b;

  always #5 clk = ~clk;

  jt12_i2s_tx #(.CLKDIV(C), .GAIN(2)) u_dut_g2 (
    .clk(clk), .rst(rst), .sample_stb(stb), .left(left), .right(right),
    .bclk(bclk_a), .lrck(lrck_a), .sdata(sdata_a), .overrun(ovr_a), .underrun(und_a)
  );

  jt12_i2s_tx #(.CLKDIV(C), .GAIN(3)) u_dut_g3 (
    .clk(clk), .rst(rst), .sample_stb(stb), .left(left), .right(right),
    .bclk(bclk_b), .lrck(lrck_b), .sdata(sdata_b), .overrun(ovr_b), .underrun(und_b)
  );

  typedef struct {
    logic [13:0] l;
    logic [13:0] r;
    logic [31:0] f2;
    logic [31:0] f3;
  } vec_t;

  typedef struct {
    logic [31:0] f2;
    logic [31:0] f3;
  } fr_t;

  vec_t        tbl [6];
  fr_t         mq[$];
  fr_t         mframe;
  fr_t         mtmp;
  logic [31:0] sb2[$];
  logic [31:0] sb3[$];
  logic [31:0] in_f2 = '0;
  logic [31:0] in_f3 = '0;
  int          checks = 0;
  int          errors = 0;
  int          ecount = 0;
  logic        armed = 1'b0;
  logic        m_rst = 1'b1;
  logic        exp_ovr = 1'b0;
  logic        exp_und = 1'b0;
  logic        e_bclk, e_lrck;

  logic [32:0] rx_sr [2];
  int          rx_nb [2];
  logic        rx_pl [2];
  int          rx_frames [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: FIFO/frame behaviour at the clk level, timing derived from clk count since reset.
  always @(posedge clk) begin
    exp_ovr = 1'b0;
    exp_und = 1'b0;
    if (rst) begin
      armed  = 1'b1;
      m_rst  = 1'b1;
      ecount = 0;
      mq.delete();
      mframe.f2 = '0;
      mframe.f3 = '0;
      sb2.delete();
      sb3.delete();
      sb2.push_back(32'd0);
      sb3.push_back(32'd0);
    end else begin
      m_rst = 1'b0;
      ecount++;
      if (ecount % P == 0) begin
        if (mq.size() != 0) mframe = mq.pop_front();
        else exp_und = 1'b1;
        sb2.push_back(mframe.f2);
        sb3.push_back(mframe.f3);
      end
      if (stb) begin
        if (mq.size() < 2) begin
          mtmp.f2 = in_f2;
          mtmp.f3 = in_f3;
          mq.push_back(mtmp);
        end else begin
          exp_ovr = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      e_bclk = ((ecount / C) % 2) == 1;
      e_lrck = ((ecount / (2 * C)) % 32) >= 16;
      chk("bclk_g2", {31'd0, bclk_a}, {31'd0, e_bclk});
      chk("bclk_g3", {31'd0, bclk_b}, {31'd0, e_bclk});
      chk("lrck_g2", {31'd0, lrck_a}, {31'd0, e_lrck});
      chk("lrck_g3", {31'd0, lrck_b}, {31'd0, e_lrck});
      chk("overrun_g2", {31'd0, ovr_a}, {31'd0, exp_ovr});
      chk("overrun_g3", {31'd0, ovr_b}, {31'd0, exp_ovr});
      chk("underrun_g2", {31'd0, und_a}, {31'd0, exp_und});
      chk("underrun_g3", {31'd0, und_b}, {31'd0, exp_und});
      if (m_rst) begin
        chk("rst_sdata_g2", {31'd0, sdata_a}, 32'd0);
        chk("rst_sdata_g3", {31'd0, sdata_b}, 32'd0);
      end
    end
  end

  task automatic rx_clr(input int g);
    rx_sr[g] = '0;
    rx_nb[g] = 0;
    rx_pl[g] = 1'b0;
  endtask

  task automatic rx_done(input int g, input logic [31:0] f);
    if (rx_nb[g] >= 32) begin
      rx_frames[g]++;
      if (g == 0) begin
        if (sb2.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_g2: got %h want <none queued>", f);
        end else begin
          chk("frame_g2", f, sb2.pop_front());
        end
      end else begin
        if (sb3.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_g3: got %h want <none queued>", f);
        end else begin
          chk("frame_g3", f, sb3.pop_front());
        end
      end
    end
    rx_nb[g] = 0;
  endtask

  // Consumer side: sample on bclk rise; a 1->0 lrck step marks the frame boundary.
  task automatic rx_bit(input int g, input logic l, input logic d);
`ifdef JT12_I2S_LJ_EN
    if (rx_pl[g] && !l) rx_done(g, rx_sr[g][31:0]);
    rx_sr[g] = {rx_sr[g][31:0], d};
    rx_nb[g]++;
`else
    rx_sr[g] = {rx_sr[g][31:0], d};
    rx_nb[g]++;
    if (rx_pl[g] && !l) rx_done(g, rx_sr[g][31:0]);
`endif
    rx_pl[g] = l;
  endtask

  always @(posedge bclk_a or posedge rst) begin
    if (rst) rx_clr(0);
    else rx_bit(0, lrck_a, sdata_a);
  end

  always @(posedge bclk_b or posedge rst) begin
    if (rst) rx_clr(1);
    else rx_bit(1, lrck_b, sdata_b);
  end

  task automatic strobe(input int i);
    left  = tbl[i].l;
    right = tbl[i].r;
    in_f2 = tbl[i].f2;
    in_f3 = tbl[i].f3;
    stb   = 1'b1;
    @(negedge clk);
    stb   = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    while ((ecount % P) != ph && n < 4 * P) begin
      @(negedge clk);
      n++;
    end
    if ((ecount % P) != ph) begin
      checks++; errors++;
      $display("FAIL wait_phase: got %0d want %0d", ecount % P, ph);
    end
  endtask

  initial begin
    tbl[0] = '{l: 14'h1FFF, r: 14'h2000, f2: 32'h7FFC_8000, f3: 32'h7FFF_8000};
    tbl[1] = '{l: 14'h0001, r: 14'h3FFF, f2: 32'h0004_FFFC, f3: 32'h0008_FFF8};
    tbl[2] = '{l: 14'h0000, r: 14'h1000, f2: 32'h0000_4000, f3: 32'h0000_7FFF};
    tbl[3] = '{l: 14'h3000, r: 14'h2001, f2: 32'hC000_8004, f3: 32'h8000_8000};
    tbl[4] = '{l: 14'h0ABC, r: 14'h3555, f2: 32'h2AF0_D554, f3: 32'h55E0_AAA8};
    tbl[5] = '{l: 14'h2ABC, r: 14'h1555, f2: 32'hAAF0_5554, f3: 32'h8000_7FFF};
    rx_clr(0);
    rx_clr(1);
    rx_frames[0] = 0;
    rx_frames[1] = 0;

    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_bclk", {31'd0, bclk_a}, 32'd0);
    chk("rst_lrck", {31'd0, lrck_a}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("bclk_first_lo", {31'd0, bclk_a}, 32'd0);
    @(negedge clk);
    chk("bclk_first_hi", {31'd0, bclk_a}, 32'd1);

    // Table: one sample per frame, first one ahead of the first wrap.
    strobe(0);
    for (int i = 1; i < 6; i++) begin
      wait_phase(P / 2);
      strobe(i);
    end

    // FIFO drains, then the last frame repeats with underrun pulses.
    repeat (3 * P) @(negedge clk);

    // Three back-to-back strobes on an empty FIFO: third is dropped.
    wait_phase(P / 4);
    strobe(2);
    strobe(3);
    strobe(4);
    repeat (4 * P) @(negedge clk);

    // Strobe coincident with a pop on an empty FIFO.
    wait_phase(P - 1);
    strobe(5);
    repeat (2 * P) @(negedge clk);

    // Mid-frame reset with a sample pending: it must be discarded.
    wait_phase(P / 2 - 10);
    strobe(0);
    wait_phase(RST_PH);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * P + 10) @(negedge clk);

    chk("frames_seen_g2", {31'd0, rx_frames[0] >= 12}, 32'd1);
    chk("frames_seen_g3", {31'd0, rx_frames[1] >= 12}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt12_i2s_tx.md
# jt12_i2s_tx

Serial audio transmitter that consumes the per-sample signed 14-bit left/right outputs of the FM channel accumulator and drives them off-chip as a 3-wire I2S stream (bclk, lrck, sdata). It sits between the accumulator and the board DAC. It provides:

- A 2-entry sample FIFO to decouple the FM sample rate from the serial frame rate.
- Gain scaling to 16-bit slots, with saturation.
- Overrun and underrun flags.

## Interface
- CLKDIV, 4: clk cycles per bclk half-period; legal range 1..255.
- GAIN, 2: left-shift applied to the sign-extended 14-bit sample; legal range 0..3.
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- sample_stb  in  1  one-cycle pulse; left/right are valid in this cycle.
- left  in  14  signed left sample.
- right  in  14  signed right sample.
- bclk  out  1  serial bit clock.
- lrck  out  1  word select: 0 = left slot, 1 = right slot.
- sdata  out  1  serial data, MSB first, two's complement.
- overrun  out  1  one-cycle pulse when a sample is dropped because the FIFO is full.
- underrun  out  1  one-cycle pulse when a frame starts with the FIFO empty.

## Operation
- Reset state:
  - bclk=0, lrck=0, sdata=0, overrun=0, underrun=0.
  - FIFO empty; frame register = 0; divider = 0; bit counter bitcnt = 0.
- Capture:
  - On sample_stb with the FIFO not full, push {left,right} (28 bits).
  - On sample_stb with the FIFO full, drop the sample and pulse overrun in the next cycle.
- Scaling, per channel:
  - Sign-extend to 17 bits, then shift left by GAIN.
  - Saturate to 16 bits: results above 32767 become 16'h7FFF; results below -32768 become 16'h8000.
  - No saturation is possible for GAIN ≤ 2.
  - Scaling is applied at pop time.
- Divider:
  - A counter runs 0..CLKDIV-1; bclk toggles when it wraps.
  - A falling bclk edge is the "shift event"; at each shift event bitcnt advances modulo 32.
- Frame:
  - 32 bclk periods per frame.
  - lrck = 0 for bitcnt 0..15 and 1 for bitcnt 16..31.
  - lrck is updated at the shift event.
- Pop:
  - At the shift event that moves bitcnt 31→0, pop the FIFO head into the frame register.
  - If the FIFO is empty, the frame register keeps its previous value (last frame repeats) and underrun pulses for one cycle.
- Serialization (default I2S alignment):
  - sdata is one bclk behind lrck.
  - At bitcnt k=1..16, sdata carries left bit 16-k.
  - At bitcnt k=17..31, sdata carries right bits 15..1.
  - The right LSB goes out at bitcnt 0 of the following frame. The previous frame's right LSB is retained across the pop.
- Simultaneous events:
  - sample_stb in the same cycle as a pop with the FIFO full: the pop frees a slot, the write is accepted, and no overrun occurs.
  - sample_stb in the same cycle as a pop with the FIFO empty: there is no bypass. underrun pulses and the sample is stored for the next frame.
- Reset mid-frame forces the reset state immediately. There is no partial-frame completion.

## Timing
- All outputs are registered; sdata and lrck change only in the clk cycle of a shift event.
- bclk period = 2·CLKDIV clk cycles; frame = 64·CLKDIV clk cycles.
- Latency, with the FIFO empty:
  - A sample pushed at cycle t is popped at the next 31→0 shift event.
  - In I2S mode, its left MSB appears one bclk period after that pop.
- overrun and underrun are high for exactly one clk cycle per event.
- The consumer samples sdata and lrck on the bclk rising edge. Data is stable for CLKDIV clk cycles on either side of that edge.

## Configuration
- JT12_I2S_LJ_EN defined: left-justified alignment.
  - sdata carries left bit 15-k at bitcnt k=0..15 and right bit 31-k at bitcnt k=16..31.
  - The MSB coincides with the lrck transition, and no previous-frame LSB is retained.
- JT12_I2S_LJ_EN undefined: standard I2S one-bit delay as described under Operation.

## Test plan
- Reset (CLKDIV=2, GAIN=2): hold rst 10 cycles, then release -> all outputs 0, first bclk rise after 2 cycles, lrck stays 0 through bitcnt 15.
- Single sample (GAIN=2): left=14'h1FFF, right=14'h2000 pushed before the first frame wraps -> captured frame shows left slot 16'h7FFC, right slot 16'h8000, MSB one bclk after each lrck edge.
- Saturation (GAIN=3): left=14'h1FFF, right=14'h2000 -> left 16'h7FFF, right 16'h8000; left=14'h0001 -> 16'h0008.
- Overrun: three sample_stb pulses within one frame with the FIFO initially empty -> first two stored, exactly one overrun pulse; next two frames carry samples 1 and 2.
- Underrun: one sample, then no strobes for 3 frames -> the sample repeats in each frame; underrun pulses once per empty pop (2 pulses); a strobe coincident with a pop on an empty FIFO yields underrun plus storage.
- Macro JT12_I2S_LJ_EN plus mid-frame reset: MSB aligned with the lrck edge; asserting rst at bitcnt 20 returns the outputs to 0 next cycle and restarts the frame at bitcnt 0 with the FIFO empty.
